// File: rtl/dual_pt_sram_pkg.sv
// dual_pt_sram_pkg: shared types, constants and byte-lane merge helper for dual_pt_sram_param
//   state_t    : init-sweep controller states
//   RDW_*      : read-during-write policy encodings
//   byte_merge : lane-wise select of new vs old bytes, sized for the widest supported word
package dual_pt_sram_pkg;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Callers zero-extend narrower words into this width and cast the result back down.
   localparam int MAX_DW = 512;
   localparam int MAX_BE = MAX_DW / 8;

   function automatic logic [MAX_DW-1:0] byte_merge(
      input logic [MAX_DW-1:0] old_word,
      input logic [MAX_DW-1:0] new_word,
      input logic [MAX_BE-1:0] be
   );
      for (int i = 0; i < MAX_BE; i++)
         byte_merge[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
   endfunction

endpackage

// File: rtl/dual_pt_sram_param_init_ctrl.sv
// sram_init_ctrl: post-reset clear sweep, one word per clock, then parks in RUN
//   clk, rst_n : clock, async active-low reset
//   clr_en     : clear write strobe, high throughout INIT
//   clr_addr   : word being cleared this cycle
//   init_done  : registered, rises on the edge that clears word DEPTH-1
module sram_init_ctrl
   import dual_pt_sram_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IW    = 4
)(
   input  logic          clk,
   input  logic          rst_n,
   output logic          clr_en,
   output logic [IW-1:0] clr_addr,
   output logic          init_done
);

   state_t        state;
   logic [IW-1:0] ptr;

   assign clr_en   = (state == ST_INIT);
   assign clr_addr = ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_INIT;
         ptr       <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               ptr <= ptr + IW'(1);
               if (ptr == IW'(DEPTH - 1)) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: rtl/dual_pt_sram_param.sv
// dual_pt_sram_param: simple dual-port SRAM, byte-lane writes, 1/2-cycle read latency, self-clearing after reset
//   clk, rst_n       : clock, async active-low reset
//   wen/waddr/wdata  : write port; wbe selects which bytes of wdata land
//   ren/raddr        : read port, fully pipelined
//   rdata/rvalid     : registered read data and one-pulse-per-read strobe; rdata holds between reads
//   init_done        : high once the post-reset clear sweep has finished
module dual_pt_sram_param
   import dual_pt_sram_pkg::*;
#(
   parameter int DW       = 8,
   parameter int AW       = 4,
   parameter int DEPTH    = 16,
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = 0
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wen,
   input  logic [AW-1:0]   waddr,
   input  logic [DW-1:0]   wdata,
   input  logic [DW/8-1:0] wbe,
   input  logic            ren,
   input  logic [AW-1:0]   raddr,
   output logic [DW-1:0]   rdata,
   output logic            rvalid,
   output logic            init_done
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DW % 8 != 0 || DW < 8 || DW > MAX_DW) begin : g_bad_dw
      $error("dual_pt_sram_param: DW must be a non-zero multiple of 8 no wider than MAX_DW");
   end
   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("dual_pt_sram_param: RD_LAT must be 1 or 2");
   end
   if (DEPTH < 1 || DEPTH > 2**AW) begin : g_bad_depth
      $error("dual_pt_sram_param: DEPTH must be in 1..2**AW");
   end
   if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
      $error("dual_pt_sram_param: RDW_MODE must be 0 or 1");
   end

   logic [DW-1:0] mem [DEPTH];
   logic          clr_en;
   logic [IW-1:0] clr_addr;
   logic          w_in, r_in, wr_ok, rd_ok;
   logic [DW-1:0] wr_word, rd_word;

   sram_init_ctrl #(.DEPTH(DEPTH), .IW(IW)) u_init (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_en    (clr_en),
      .clr_addr  (clr_addr),
      .init_done (init_done)
   );

   // Widened compare so DEPTH == 2**AW still fits.
   assign w_in    = {1'b0, waddr} < (AW+1)'(DEPTH);
   assign r_in    = {1'b0, raddr} < (AW+1)'(DEPTH);
   assign wr_ok   = init_done & wen & w_in;
   assign rd_ok   = init_done & ren;
   assign wr_word = DW'(byte_merge(MAX_DW'(mem[waddr[IW-1:0]]), MAX_DW'(wdata), MAX_BE'(wbe)));
   // Same-address collision in new-data mode forwards the merged write word; otherwise the
   // array read sees the pre-edge contents, which is exactly the old-data result.
   assign rd_word = !r_in ? '0
                  : (RDW_MODE == RDW_NEW && wr_ok && waddr == raddr) ? wr_word
                  : mem[raddr[IW-1:0]];

   // The clear sweep owns the write port during INIT; user writes are gated by init_done.
   always_ff @(posedge clk) begin
      if (clr_en)
         mem[clr_addr] <= '0;
      else if (wr_ok)
         mem[waddr[IW-1:0]] <= wr_word;
   end

   logic [DW-1:0] d1;
   logic          v1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= rd_ok;
         if (rd_ok)
            d1 <= rd_word;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic [DW-1:0] d2;
      logic          v2;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            d2 <= '0;
            v2 <= 1'b0;
         end else begin
            v2 <= v1;
            if (v1)
               d2 <= d1;
         end
      end
      assign rdata  = d2;
      assign rvalid = v2;
   end else begin : g_lat1
      assign rdata  = d1;
      assign rvalid = v1;
   end

endmodule

// File: tb/tb_dual_pt_sram_param.sv
// tb_dual_pt_sram_param: three configurations driven by one directed stimulus stream, checked by per-instance scoreboards
//   u0: DEPTH=16 RD_LAT=1 RDW_MODE=0
//   u1: DEPTH=16 RD_LAT=2 RDW_MODE=1
//   u2: DEPTH=12 RD_LAT=2 RDW_MODE=0
module tb_dual_pt_sram_param;

   typedef struct packed {
      int          c;
      logic [15:0] d;
   } exp_t;

   localparam int LAT [3] = '{1, 2, 2};
   localparam int DEP [3] = '{16, 16, 12};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wen = 1'b0, ren = 1'b0;
   logic [3:0]  waddr = '0, raddr = '0;
   logic [15:0] wdata = '0;
   logic [1:0]  wbe = '0;
   logic [15:0] rdata [3];
   logic        rvalid [3];
   logic        init_done [3];
   logic [15:0] held [3];
   int          cyc = 0, total = 0, bad = 0;
   exp_t        q0[$], q1[$], q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dual_pt_sram_param #(.DW(16), .AW(4), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .ren(ren), .raddr(raddr), .rdata(rdata[0]), .rvalid(rvalid[0]), .init_done(init_done[0]));
   dual_pt_sram_param #(.DW(16), .AW(4), .DEPTH(16), .RD_LAT(2), .RDW_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .ren(ren), .raddr(raddr), .rdata(rdata[1]), .rvalid(rvalid[1]), .init_done(init_done[1]));
   dual_pt_sram_param #(.DW(16), .AW(4), .DEPTH(12), .RD_LAT(2), .RDW_MODE(0)) u2 (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .ren(ren), .raddr(raddr), .rdata(rdata[2]), .rvalid(rvalid[2]), .init_done(init_done[2]));

   task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s dut%0d got=%0h expected=%0h at t=%0t", name, k, got, exp, $time);
      end
   endtask

   function automatic void push(input int k, input logic [15:0] d);
      exp_t e;
      e.c = cyc + LAT[k];
      e.d = d;
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction

   function automatic int qsize(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic exp_t qpop(input int k);
      case (k)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   // Monitor: every rvalid pops one expectation (cycle and data); idle cycles must hold rdata.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n)
            held[k] = '0;
         else if (rvalid[k]) begin
            if (qsize(k) == 0)
               chk("rvalid_unexpected", k, 32'(rvalid[k]), 32'd0);
            else begin
               exp_t e;
               e = qpop(k);
               chk("rd_cycle", k, cyc, e.c);
               chk("rd_data", k, 32'(rdata[k]), 32'(e.d));
            end
            held[k] = rdata[k];
         end else
            chk("rdata_hold", k, 32'(rdata[k]), 32'(held[k]));
      end
   end

   task automatic step(input logic we, input logic [3:0] wa, input logic [15:0] wd, input logic [1:0] be,
                       input logic re, input logic [3:0] ra,
                       input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
      @(negedge clk);
      wen = we; waddr = wa; wdata = wd; wbe = be;
      ren = re; raddr = ra;
      if (re) begin
         push(0, e0);
         push(1, e1);
         push(2, e2);
      end
   endtask

   // Park raddr on a different word so a non-holding output register would show up.
   task automatic idle();
      step(1'b0, 4'h0, 16'h0, 2'b00, 1'b0, 4'hF, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      step(1'b1, a, d, be, 1'b0, 4'hF, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic rd(input logic [3:0] a, input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
      step(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, a, e0, e1, e2);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_rdata", k, 32'(rdata[k]), 32'd0);
         chk("rst_rvalid", k, 32'(rvalid[k]), 32'd0);
         chk("rst_init_done", k, 32'(init_done[k]), 32'd0);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++)
            chk("init_done_edge", k, 32'(init_done[k]), 32'(i >= DEP[k]));
      end
      for (int a = 0; a < 16; a++)
         rd(4'(a), 16'h0000, 16'h0000, 16'h0000);
      idle();
      // full-word write then read
      wr(4'd3, 16'hA5C3, 2'b11);
      rd(4'd3, 16'hA5C3, 16'hA5C3, 16'hA5C3);
      idle();
      // low lane only, then a no-op write
      wr(4'd3, 16'h1234, 2'b01);
      rd(4'd3, 16'hA534, 16'hA534, 16'hA534);
      wr(4'd3, 16'hFFFF, 2'b00);
      rd(4'd3, 16'hA534, 16'hA534, 16'hA534);
      idle();
      // same-address collision: old data on u0/u2, merged data on u1
      wr(4'd5, 16'h00FF, 2'b11);
      step(1'b1, 4'd5, 16'hBEEF, 2'b10, 1'b1, 4'd5, 16'h00FF, 16'hBEFF, 16'h00FF);
      rd(4'd5, 16'hBEFF, 16'hBEFF, 16'hBEFF);
      idle();
      // independent write and read on different addresses in one cycle
      step(1'b1, 4'd7, 16'h7777, 2'b11, 1'b1, 4'd3, 16'hA534, 16'hA534, 16'hA534);
      rd(4'd7, 16'h7777, 16'h7777, 16'h7777);
      idle();
      // address 13 is beyond u2's 12 words: write dropped, read returns 0, no aliasing onto 1
      wr(4'd13, 16'hFFFF, 2'b11);
      rd(4'd13, 16'hFFFF, 16'hFFFF, 16'h0000);
      rd(4'd1, 16'h0000, 16'h0000, 16'h0000);
      repeat (4) idle();
      // reset with reads in flight: only u0's first read has completed beforehand
      @(negedge clk);
      ren = 1'b1; raddr = 4'd3;
      push(0, 16'hA534);
      @(negedge clk);
      raddr = 4'd5;
      #1 rst_n = 1'b0;
      ren = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("midrst_rdata", k, 32'(rdata[k]), 32'd0);
         chk("midrst_rvalid", k, 32'(rvalid[k]), 32'd0);
         chk("midrst_init_done", k, 32'(init_done[k]), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wen = 1'b1; waddr = 4'd3; wdata = 16'hDEAD; wbe = 2'b11;
      ren = 1'b1; raddr = 4'd3;
      repeat (10) @(negedge clk);
      wen = 1'b0; ren = 1'b0;
      n = 0;
      while (!(init_done[0] && init_done[1] && init_done[2]) && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 3; k++)
         chk("reinit_done", k, 32'(init_done[k]), 32'd1);
      rd(4'd3, 16'h0000, 16'h0000, 16'h0000);
      rd(4'd5, 16'h0000, 16'h0000, 16'h0000);
      repeat (4) idle();
      for (int k = 0; k < 3; k++)
         chk("queue_drained", k, 32'(qsize(k)), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
